// File: rtl/wb_pkg.sv
//------------------------------------------------------------------------------
// Module  : wb_pkg
// Brief   : Shared types and constants for the write-back stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG_IDX = 5'd31;

   typedef enum logic [1:0] {
      WB_IDLE     = 2'd0,
      WB_WAIT_MEM = 2'd1,
      WB_COMMIT   = 2'd2
   } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_timeout_counter.sv
//------------------------------------------------------------------------------
// Module  : wb_timeout_counter
// Brief   : 8-bit saturating wait counter with terminal-count flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_timeout_counter #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam logic [7:0] c_TERMINAL_CNT = 8'(MEM_TIMEOUT - 1);

   logic [7:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 8'd0;
      end else if (i_clear) begin
         r_count <= 8'd0;
      end else if (i_enable && (r_count != 8'hFF)) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign o_terminal = (r_count == c_TERMINAL_CNT);

endmodule

`default_nettype wire

// File: rtl/write_back_stage.sv
//------------------------------------------------------------------------------
// Module  : write_back_stage
// Brief   : Final pipeline stage; drives the register-file write port and the
//           forwarding mirror, waiting for load data with a bounded timeout.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module write_back_stage
   import wb_pkg::*;
#(
   parameter int                    DATA_W      = 32,
   parameter int                    MEM_TIMEOUT = 15,
   parameter logic [REG_ADDR_W-1:0] ZERO_REG    = ZERO_REG_IDX
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  inValid,
   output logic                  inReady,
   input  logic                  inRegWrite,
   input  logic                  inMemToReg,
   input  logic [REG_ADDR_W-1:0] inDestReg,
   input  logic [DATA_W-1:0]     inAluResult,
   input  logic                  memDataValid,
   input  logic [DATA_W-1:0]     memData,
   output logic                  regWrite,
   output logic [REG_ADDR_W-1:0] writeRegister,
   output logic [DATA_W-1:0]     writeData,
   output logic                  fwdValid,
   output logic [REG_ADDR_W-1:0] fwdReg,
   output logic [DATA_W-1:0]     fwdData,
   output logic                  memTimeout
);

   wb_state_t             r_state;
   logic                  r_pendWr;
   logic [REG_ADDR_W-1:0] r_pendDest;

   logic                  w_accept;
   logic                  w_destWritable;
   logic                  w_terminal;
   logic                  w_cntClear;
   logic                  w_cntEnable;
   logic                  w_commitWr;
   logic [REG_ADDR_W-1:0] w_commitReg;
   logic [DATA_W-1:0]     w_commitData;

   assign inReady        = (r_state != WB_WAIT_MEM);
   assign w_accept       = inValid && inReady;
   assign w_destWritable = inRegWrite && (inDestReg != ZERO_REG);

   // Result mux: load data while waiting on memory, ALU result otherwise.
   always_comb begin
      w_commitWr   = 1'b0;
      w_commitReg  = inDestReg;
      w_commitData = inAluResult;
      if (r_state == WB_WAIT_MEM) begin
         w_commitWr   = r_pendWr && memDataValid;
         w_commitReg  = r_pendDest;
         w_commitData = memData;
      end else if (w_accept && !inMemToReg) begin
         w_commitWr   = w_destWritable;
      end
   end

   assign w_cntClear  = w_accept && inMemToReg;
   assign w_cntEnable = (r_state == WB_WAIT_MEM) && !memDataValid;

   wb_timeout_counter #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timeout_counter (
      .clk        (clock),
      .rst        (reset),
      .i_clear    (w_cntClear),
      .i_enable   (w_cntEnable),
      .o_terminal (w_terminal)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= WB_IDLE;
         r_pendWr      <= 1'b0;
         r_pendDest    <= '0;
         regWrite      <= 1'b0;
         writeRegister <= '0;
         writeData     <= '0;
         fwdValid      <= 1'b0;
         fwdReg        <= '0;
         fwdData       <= '0;
         memTimeout    <= 1'b0;
      end else begin
         regWrite <= w_commitWr;
         fwdValid <= w_commitWr;
         if (w_commitWr) begin
            writeRegister <= w_commitReg;
            writeData     <= w_commitData;
            fwdReg        <= w_commitReg;
            fwdData       <= w_commitData;
         end

         case (r_state)
            WB_IDLE, WB_COMMIT: begin
               if (w_accept && inMemToReg) begin
                  r_state    <= WB_WAIT_MEM;
                  r_pendWr   <= w_destWritable;
                  r_pendDest <= inDestReg;
               end else if (w_accept) begin
                  r_state <= WB_COMMIT;
               end else begin
                  r_state <= WB_IDLE;
               end
            end
            WB_WAIT_MEM: begin
               // Data arriving on the terminal cycle still commits.
               if (memDataValid) begin
                  r_state <= WB_COMMIT;
               end else if (w_terminal) begin
                  r_state    <= WB_IDLE;
                  memTimeout <= 1'b1;
               end
            end
            default: r_state <= WB_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_write_back_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_write_back_stage
// Brief   : Directed self-checking bench for write_back_stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_write_back_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        inValid = 1'b0;
   logic        inReady;
   logic        inRegWrite = 1'b0;
   logic        inMemToReg = 1'b0;
   logic [4:0]  inDestReg = '0;
   logic [31:0] inAluResult = '0;
   logic        memDataValid = 1'b0;
   logic [31:0] memData = '0;
   logic        regWrite;
   logic [4:0]  writeRegister;
   logic [31:0] writeData;
   logic        fwdValid;
   logic [4:0]  fwdReg;
   logic [31:0] fwdData;
   logic        memTimeout;

   int r_total = 0;
   int r_passed = 0;

   always #5 clock = ~clock;

   write_back_stage #(
      .DATA_W      (32),
      .MEM_TIMEOUT (15),
      .ZERO_REG    (5'd31)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .inValid       (inValid),
      .inReady       (inReady),
      .inRegWrite    (inRegWrite),
      .inMemToReg    (inMemToReg),
      .inDestReg     (inDestReg),
      .inAluResult   (inAluResult),
      .memDataValid  (memDataValid),
      .memData       (memData),
      .regWrite      (regWrite),
      .writeRegister (writeRegister),
      .writeData     (writeData),
      .fwdValid      (fwdValid),
      .fwdReg        (fwdReg),
      .fwdData       (fwdData),
      .memTimeout    (memTimeout)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      r_total++;
      if (got === exp) r_passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_op(input logic v, input logic rw, input logic m2r,
                           input logic [4:0] dst, input logic [31:0] alu);
      inValid     = v;
      inRegWrite  = rw;
      inMemToReg  = m2r;
      inDestReg   = dst;
      inAluResult = alu;
   endtask

   initial begin
      #12;
      check("rst_regWrite", 64'(regWrite), 64'd0);
      check("rst_wreg", 64'(writeRegister), 64'd0);
      check("rst_wdata", 64'(writeData), 64'd0);
      check("rst_fwdValid", 64'(fwdValid), 64'd0);
      check("rst_timeout", 64'(memTimeout), 64'd0);
      check("rst_inReady", 64'(inReady), 64'd1);
      @(negedge clock);
      reset = 1'b0;
      tick();

      // 1: single ALU write
      drive_op(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234);
      tick();
      drive_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      check("alu_regWrite", 64'(regWrite), 64'd1);
      check("alu_wreg", 64'(writeRegister), 64'd5);
      check("alu_wdata", 64'(writeData), 64'h1234);
      check("alu_fwdValid", 64'(fwdValid), 64'd1);
      check("alu_fwdReg", 64'(fwdReg), 64'd5);
      check("alu_fwdData", 64'(fwdData), 64'h1234);
      tick();
      check("alu_regWrite_off", 64'(regWrite), 64'd0);
      check("alu_fwd_off", 64'(fwdValid), 64'd0);
      check("alu_wreg_hold", 64'(writeRegister), 64'd5);

      // 2: load, data arrives on the third wait cycle
      drive_op(1'b1, 1'b1, 1'b1, 5'd7, 32'h5555);
      tick();
      drive_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("ld_inReady_%0d", i), 64'(inReady), 64'd0);
         check($sformatf("ld_fwd_%0d", i), 64'(fwdValid), 64'd0);
         if (i == 2) begin
            memDataValid = 1'b1;
            memData      = 32'hDEADBEEF;
         end
         tick();
      end
      memDataValid = 1'b0;
      check("ld_regWrite", 64'(regWrite), 64'd1);
      check("ld_wreg", 64'(writeRegister), 64'd7);
      check("ld_wdata", 64'(writeData), 64'hDEADBEEF);
      check("ld_fwdData", 64'(fwdData), 64'hDEADBEEF);
      check("ld_inReady_back", 64'(inReady), 64'd1);
      tick();
      check("ld_regWrite_off", 64'(regWrite), 64'd0);

      // 3: XZR destination, then an op with inRegWrite=0
      drive_op(1'b1, 1'b1, 1'b0, 5'd31, 32'hFFFF);
      tick();
      check("xzr_regWrite", 64'(regWrite), 64'd0);
      check("xzr_fwdValid", 64'(fwdValid), 64'd0);
      check("xzr_wreg_hold", 64'(writeRegister), 64'd7);
      drive_op(1'b1, 1'b0, 1'b0, 5'd4, 32'hABCD);
      tick();
      drive_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      check("norw_regWrite", 64'(regWrite), 64'd0);
      check("norw_wdata_hold", 64'(writeData), 64'hDEADBEEF);
      tick();

      // 4: back-to-back ALU ops
      for (int i = 1; i <= 3; i++) begin
         drive_op(1'b1, 1'b1, 1'b0, 5'(i), 32'h100 + 32'(i));
         check($sformatf("b2b_inReady_%0d", i), 64'(inReady), 64'd1);
         tick();
         check($sformatf("b2b_regWrite_%0d", i), 64'(regWrite), 64'd1);
         check($sformatf("b2b_wreg_%0d", i), 64'(writeRegister), 64'(i));
         check($sformatf("b2b_wdata_%0d", i), 64'(writeData), 64'h100 + 64'(i));
      end
      drive_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      check("b2b_regWrite_off", 64'(regWrite), 64'd0);

      // 5: load timeout after 15 wait cycles
      drive_op(1'b1, 1'b1, 1'b1, 5'd9, 32'h0);
      tick();
      drive_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 15; i++) begin
         check($sformatf("to_inReady_%0d", i), 64'(inReady), 64'd0);
         check($sformatf("to_flag_%0d", i), 64'(memTimeout), 64'd0);
         check($sformatf("to_regWrite_%0d", i), 64'(regWrite), 64'd0);
         tick();
      end
      check("to_flag_set", 64'(memTimeout), 64'd1);
      check("to_inReady_back", 64'(inReady), 64'd1);
      check("to_regWrite", 64'(regWrite), 64'd0);
      memDataValid = 1'b1;
      memData      = 32'h77777777;
      tick();
      memDataValid = 1'b0;
      check("to_late_regWrite", 64'(regWrite), 64'd0);
      check("to_late_wdata", 64'(writeData), 64'h103);
      check("to_flag_sticky", 64'(memTimeout), 64'd1);
      tick();

      // 6: async reset while waiting on a load
      drive_op(1'b1, 1'b1, 1'b1, 5'd12, 32'h0);
      tick();
      drive_op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      check("rml_waiting", 64'(inReady), 64'd0);
      #2 reset = 1'b1;
      #1;
      check("rml_inReady", 64'(inReady), 64'd1);
      check("rml_timeout", 64'(memTimeout), 64'd0);
      check("rml_wreg", 64'(writeRegister), 64'd0);
      check("rml_wdata", 64'(writeData), 64'd0);
      check("rml_fwdReg", 64'(fwdReg), 64'd0);
      #2 reset = 1'b0;
      memDataValid = 1'b1;
      memData      = 32'hCAFEF00D;
      tick();
      memDataValid = 1'b0;
      check("rml_regWrite", 64'(regWrite), 64'd0);
      check("rml_wdata_after", 64'(writeData), 64'd0);
      tick();

      $display("%0d/%0d checks passed", r_passed, r_total);
      $finish;
   end

endmodule

`default_nettype wire
